// File: rtl/fp32_pkg.sv
// Shared binary32 constants, unpacked operand type, FSM states and the
// unpack helper used by the stream accumulator.
package fp32_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam int          EXP_INF   = 2 * EXP_BIAS + 1;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP32_QNAN = 32'h7FFFFFFF;
  localparam int          SIG_W     = 24;
  localparam int          GRS_W     = 3;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [27:0]       sig;
  } fp32_unpacked_t;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_OUT
  } state_t;

  // Hidden bit lands on bit 26 with three zero GRS bits below; exp=0 reads as denormal.
  function automatic fp32_unpacked_t fp32Unpack(input logic [31:0] word);
    fp32_unpacked_t u;
    u.sign = word[31];
    u.exp  = (word[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, word[30:23]});
    u.sig  = {1'b0, (word[30:23] != 8'd0), word[22:0], 3'b000};
    return u;
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// 28-bit combinational leading-zero counter; an all-zero input reports 28.
module fp32_lzc (
  input  logic [27:0] value_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value_i[i]) count_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp32_stream_accumulator.sv
// Sums a stream of binary32 terms into one binary32 total per in_last-delimited
// group, using one align/add/normalize/round datapath stepped five cycles per term.
module fp32_stream_accumulator
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int MANT_W = SIG_W + GRS_W;

  state_t            state_q;
  logic [31:0]       acc_q, term_q, outData_q;
  logic [CNT_W-1:0]  count_q, outCount_q;
  logic              nan_q, inf_q, infSign_q, last_q, inReady_q, outValid_q;
  logic              bigSign_q, smallSign_q, sign_q;
  logic signed [9:0] exp_q;
  logic [27:0]       bigSig_q, smallSig_q, sum_q;
  logic [MANT_W-1:0] norm_q;

  fp32_unpacked_t    accU, termU, bigU, smallU;
  logic signed [9:0] expDiff;
  logic [4:0]        shAmt;
  logic [27:0]       shMask, alignSmall_d;
  logic              termIsNan, termIsInf;

  assign termIsNan = (term_q[30:23] == EXP_MAX) && (term_q[22:0] != 23'd0);
  assign termIsInf = (term_q[30:23] == EXP_MAX) && (term_q[22:0] == 23'd0);

  always_comb begin
    accU  = fp32Unpack(acc_q);
    termU = fp32Unpack(term_q);
    if ($signed(termU.exp) > $signed(accU.exp)) begin
      bigU   = termU;
      smallU = accU;
    end else begin
      bigU   = accU;
      smallU = termU;
    end
    expDiff      = $signed(bigU.exp) - $signed(smallU.exp);
    shAmt        = (expDiff > 10'sd27) ? 5'd27 : expDiff[4:0];
    shMask       = (28'd1 << shAmt) - 28'd1;
    alignSmall_d = smallU.sig >> shAmt;
    alignSmall_d[0] = alignSmall_d[0] | (|(smallU.sig & shMask));
  end

  logic [27:0] sum_d;
  logic        sign_d;

  // Exact cancellation of opposite signs yields +0; equal signs keep the sign.
  always_comb begin
    sum_d  = bigSig_q + smallSig_q;
    sign_d = bigSign_q;
    if (bigSign_q != smallSign_q) begin
      if (bigSig_q >= smallSig_q) begin
        sum_d = bigSig_q - smallSig_q;
      end else begin
        sum_d  = smallSig_q - bigSig_q;
        sign_d = smallSign_q;
      end
      if (sum_d == 28'd0) sign_d = 1'b0;
    end
  end

  logic [4:0]        lzCount, normShift;
  logic [MANT_W-1:0] norm_d;
  logic signed [9:0] normExp_d;

  fp32_lzc uLzc (
    .value_i (sum_q),
    .count_o (lzCount)
  );

  // Without a carry the hidden bit belongs on bit 26, one below the sum MSB.
  always_comb begin
    normShift = lzCount - 5'd1;
    if (sum_q[27]) begin
      norm_d    = sum_q[27:1] | {26'd0, sum_q[0]};
      normExp_d = exp_q + 10'sd1;
    end else begin
      norm_d    = sum_q[26:0] << normShift;
      normExp_d = exp_q - $signed({5'd0, normShift});
    end
  end

  logic              roundUp, ovf;
  logic [24:0]       mantR;
  logic signed [9:0] expR;
  logic [31:0]       rounded;

  always_comb begin
    roundUp = norm_q[2] & (norm_q[3] | norm_q[1] | norm_q[0]);
    mantR   = {1'b0, norm_q[26:3]} + {24'd0, roundUp};
    expR    = mantR[24] ? exp_q + 10'sd1 : exp_q;
    ovf     = norm_q[26] && (int'(expR) >= EXP_INF);
    if (!norm_q[26] || expR < 10'sd1) begin
      rounded = {sign_q, 31'd0};
    end else begin
      rounded = {sign_q, expR[7:0], (mantR[24] ? mantR[23:1] : mantR[22:0])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCEPT;
      acc_q       <= 32'd0;
      term_q      <= 32'd0;
      count_q     <= '0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      infSign_q   <= 1'b0;
      last_q      <= 1'b0;
      bigSign_q   <= 1'b0;
      smallSign_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      bigSig_q    <= 28'd0;
      smallSig_q  <= 28'd0;
      sum_q       <= 28'd0;
      norm_q      <= '0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      outData_q   <= 32'd0;
      outCount_q  <= '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_valid && inReady_q) begin
            term_q    <= in_data;
            last_q    <= in_last;
            inReady_q <= 1'b0;
            if (count_q != '1) count_q <= count_q + 1'b1;
            state_q   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          bigSig_q    <= bigU.sig;
          smallSig_q  <= alignSmall_d;
          bigSign_q   <= bigU.sign;
          smallSign_q <= smallU.sign;
          exp_q       <= bigU.exp;
          if (termIsNan) begin
            nan_q <= 1'b1;
          end else if (termIsInf) begin
            if (inf_q && (infSign_q != term_q[31])) begin
              nan_q <= 1'b1;
            end else begin
              inf_q     <= 1'b1;
              infSign_q <= term_q[31];
            end
          end
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          sign_q  <= sign_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          norm_q  <= norm_d;
          exp_q   <= normExp_d;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          // Once a special flag is up, finite terms no longer touch the accumulator.
          if (!nan_q && !inf_q) begin
            if (ovf) begin
              inf_q     <= 1'b1;
              infSign_q <= sign_q;
            end else begin
              acc_q <= rounded;
            end
          end
          if (last_q) begin
            if (nan_q)      outData_q <= FP32_QNAN;
            else if (inf_q) outData_q <= {infSign_q, EXP_MAX, 23'd0};
            else if (ovf)   outData_q <= {sign_q, EXP_MAX, 23'd0};
            else            outData_q <= rounded;
            outCount_q <= count_q;
            outValid_q <= 1'b1;
            state_q    <= S_OUT;
          end else begin
            inReady_q <= 1'b1;
            state_q   <= S_ACCEPT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc_q      <= 32'd0;
            count_q    <= '0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            infSign_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= 32'd0;
            outCount_q <= '0;
            inReady_q  <= 1'b1;
            state_q    <= S_ACCEPT;
          end
        end
        default: state_q <= S_ACCEPT;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_count = outCount_q;

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Directed scoreboard bench for fp32_stream_accumulator; a second instance with
// a 2-bit counter runs in lockstep to cover count saturation.
module tb_fp32_stream_accumulator;

  typedef struct {
    logic [31:0] data;
    int          count;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        satInReady, satOutValid;
  logic [31:0] satOutData;
  logic [1:0]  satOutCount;

  expect_t sbQ[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  fp32_stream_accumulator #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  fp32_stream_accumulator #(.CNT_W(2)) dutSat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (satInReady),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (satOutValid),
    .out_ready (out_ready),
    .out_data  (satOutData),
    .out_count (satOutCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectGroup(input logic [31:0] data, input int count);
    expect_t e;
    e.data  = data;
    e.count = count;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last);
    bit ready;
    ready = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) begin
      @(negedge clk);
      ready = in_ready;
    end
    checkVal("in_ready_wait", {31'd0, ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the in_last handshake edge; lat counts the cycle index.
  task automatic checkOutput(input int expLatency, input int holdCycles);
    int      lat;
    bit      seen;
    expect_t e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else @(posedge clk);
    end
    checkVal("out_valid_wait", {31'd0, seen}, 32'd1);
    if (seen) begin
      checkVal("latency", lat, expLatency);
      checks++;
      assert (sbQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL scoreboard: observed %0d entries expected nonzero", sbQ.size());
      end
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkVal("out_data", out_data, e.data);
        checkVal("out_count", {16'd0, out_count}, e.count);
        checkVal("sat_out_valid", {31'd0, satOutValid}, 32'd1);
        checkVal("sat_out_data", satOutData, e.data);
        checkVal("sat_out_count", {30'd0, satOutCount}, (e.count > 3) ? 3 : e.count);
        for (int h = 0; h < holdCycles; h++) begin
          @(posedge clk);
          @(negedge clk);
          checkVal("hold_out_valid", {31'd0, out_valid}, 32'd1);
          checkVal("hold_in_ready", {31'd0, in_ready}, 32'd0);
          checkVal("hold_out_data", out_data, e.data);
          checkVal("hold_out_count", {16'd0, out_count}, e.count);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset_out_data", out_data, 32'd0);
    checkVal("reset_out_count", {16'd0, out_count}, 32'd0);
    checkVal("reset_sat_in_ready", {31'd0, satInReady}, 32'd1);

    applyStimulus(32'h3F800000, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    expectGroup(32'h40C00000, 3);
    applyStimulus(32'h40400000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h3F800000, 1'b0);
    expectGroup(32'h00000000, 2);
    applyStimulus(32'hBF800000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h3F800000, 1'b0);
    expectGroup(32'h3F800000, 2);
    applyStimulus(32'h33800000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h3F800000, 1'b0);
    expectGroup(32'h3F800001, 2);
    applyStimulus(32'h33800001, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h3F800000, 1'b0);
    expectGroup(32'h3E800000, 2);
    applyStimulus(32'hBF400000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h7F800000, 1'b0);
    expectGroup(32'h7FFFFFFF, 2);
    applyStimulus(32'hFF800000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h7F7FFFFF, 1'b0);
    expectGroup(32'h7F800000, 2);
    applyStimulus(32'h7F7FFFFF, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h7FC00000, 1'b0);
    expectGroup(32'h7FFFFFFF, 2);
    applyStimulus(32'h3F800000, 1'b1);
    checkOutput(5, 0);

    expectGroup(32'h3F800000, 1);
    applyStimulus(32'h3F800000, 1'b1);
    checkOutput(5, 10);
    expectGroup(32'h40000000, 1);
    applyStimulus(32'h40000000, 1'b1);
    checkOutput(5, 0);

    applyStimulus(32'h3F800000, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkVal("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    expectGroup(32'h40000000, 1);
    applyStimulus(32'h40000000, 1'b1);
    checkOutput(5, 0);

    for (int t = 0; t < 4; t++) applyStimulus(32'h3F800000, 1'b0);
    expectGroup(32'h40A00000, 5);
    applyStimulus(32'h3F800000, 1'b1);
    checkOutput(5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
